// File: rtl/ram_pkg.sv
// ============================================================================
// Module   : ram_pkg
// Purpose  : Shared definitions for the parametrised dual-port RAM. Holds the
//            read-during-write mode encodings, the clear-FSM state encoding
//            and the byte-merge helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_pkg;

  // Same-address read/write collision behaviour
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest word byte_merge can handle. Callers size-cast in and out.
  localparam int MERGE_MAX_W = 256;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_READY = 2'd2
  } clr_state_e;

  // Take bytes of new_word where be is set, keep old_word bytes elsewhere.
  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]   old_word,
    input logic [MERGE_MAX_W-1:0]   new_word,
    input logic [MERGE_MAX_W/8-1:0] be
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MERGE_MAX_W/8; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_clear_fsm.sv
// ============================================================================
// Module   : ram_clear_fsm
// Purpose  : Post-reset clear engine. Walks every address once, issuing a
//            zero-write per cycle, then reports ready.
// Ports    : clk          in  clock
//            rst_n        in  asynchronous active-low reset
//            init_busy_o  out high while clearing (and in the IDLE fallback)
//            clr_we_o     out clear write enable
//            clr_addr_o   out clear write address
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam int DEPTH = 1 << ADDR_W;
  // Counter is one bit wider than the address so the terminal compare
  // never sees a wrapped value.
  localparam logic [ADDR_W:0] c_last_addr = (ADDR_W+1)'(DEPTH-1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET) state_q <= CLR_CLEAR;
      else                state_q <= CLR_READY;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_busy_o = 1'b1;
    clr_we_o    = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        state_d   = CLR_CLEAR;
        clr_cnt_d = '0;
      end
      CLR_CLEAR: begin
        clr_we_o  = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == c_last_addr) state_d = CLR_READY;
      end
      CLR_READY: begin
        init_busy_o = 1'b0;
      end
      default: begin
        // Unused encoding: recover through a fresh clear
        state_d   = CLR_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  assign clr_addr_o = clr_cnt_q[ADDR_W-1:0];

endmodule

`default_nettype wire

// File: rtl/param_sync_ram_dp.sv
// ============================================================================
// Module   : param_sync_ram_dp
// Purpose  : Simple dual-port synchronous RAM (one write, one read port) with
//            byte enables, 1- or 2-cycle read latency, selectable
//            read-during-write behaviour, read-valid strobe and a post-reset
//            clear engine.
// Ports    : clk, rst_n          clock, async active-low reset
//            init_busy           high while the clear runs; traffic dropped
//            wr_en/addr/be/data  write port
//            rd_en/addr          read request
//            rd_data/rd_valid    read result and its one-cycle strobe
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_sync_ram_dp
  import ram_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int RD_LAT         = 1,
  parameter int RDW_MODE       = 0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                init_busy,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_acc, rd_acc, collide;
  logic [DATA_W-1:0] rd_mem_word, rd_merged, rd_word;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  ram_clear_fsm #(
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_busy_o (init_busy),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr)
  );

  assign wr_acc = wr_en & ~init_busy;
  assign rd_acc = rd_en & ~init_busy;

  // The clear only writes while init_busy is high, when user writes are
  // already blocked, so the two write sources never compete.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_be[b]) mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Write-first bypass: on a same-address collision the read sees the word
  // as it will look after this cycle's write.
  assign rd_mem_word = mem_q[rd_addr];
  assign rd_merged   = DATA_W'(byte_merge(MERGE_MAX_W'(rd_mem_word),
                                          MERGE_MAX_W'(wr_data),
                                          (MERGE_MAX_W/8)'(wr_be)));
  assign collide     = wr_acc && rd_acc && (wr_addr == rd_addr);
  assign rd_word     = ((RDW_MODE == RDW_WRITE_FIRST) && collide) ? rd_merged
                                                                 : rd_mem_word;

  // Any RD_LAT other than 2 builds the single-stage pipeline.
  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] s1_data_q;
    logic              s1_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_data_q  <= '0;
        s1_valid_q <= 1'b0;
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        s1_valid_q <= rd_acc;
        if (rd_acc) s1_data_q <= rd_word;
        rd_valid_q <= s1_valid_q;
        if (s1_valid_q) rd_data_q <= s1_data_q;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= rd_word;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_param_sync_ram_dp.sv
// ============================================================================
// Module   : tb_param_sync_ram_dp
// Purpose  : Directed self-checking bench. Three instances share stimulus:
//            A = 8-bit, RD_LAT=1, READ_FIRST, clear on reset
//            B = 32-bit, RD_LAT=2, WRITE_FIRST, clear on reset
//            C = 8-bit, RD_LAT=2, READ_FIRST, no clear
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_sync_ram_dp;

  logic        clk;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [3:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  logic        a_busy, a_rd_valid;
  logic [7:0]  a_rd_data;
  logic        b_busy, b_rd_valid;
  logic [31:0] b_rd_data;
  logic        c_busy, c_rd_valid;
  logic [7:0]  c_rd_data;

  int errors = 0;
  int checks = 0;

  param_sync_ram_dp #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(0),
                      .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .init_busy(a_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be[0:0]), .wr_data(wr_data[7:0]),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid)
  );

  param_sync_ram_dp #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .RDW_MODE(1),
                      .CLEAR_ON_RESET(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .init_busy(b_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
  );

  param_sync_ram_dp #(.DATA_W(8), .ADDR_W(4), .RD_LAT(2), .RDW_MODE(0),
                      .CLEAR_ON_RESET(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .init_busy(c_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be[0:0]), .wr_data(wr_data[7:0]),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(c_rd_data), .rd_valid(c_rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_valid;
    logic [31:0] seen_data;

    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    repeat (3) tick();

    // Reset state
    check("rst_busy_a",  32'(a_busy), 32'd1);
    check("rst_busy_b",  32'(b_busy), 32'd1);
    check("rst_busy_c",  32'(c_busy), 32'd0);
    check("rst_data_a",  32'(a_rd_data), 32'd0);
    check("rst_data_b",  b_rd_data, 32'd0);
    check("rst_valid_a", 32'(a_rd_valid), 32'd0);
    check("rst_valid_b", 32'(b_rd_valid), 32'd0);

    // Release reset with requests pending: all must be dropped during clear
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd0;
    seen_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen_valid = seen_valid | a_rd_valid | b_rd_valid;
    end
    check("clr_busy15_a", 32'(a_busy), 32'd1);
    check("clr_busy15_b", 32'(b_busy), 32'd1);
    wr_en = 1'b0; rd_en = 1'b0;
    tick();
    seen_valid = seen_valid | a_rd_valid | b_rd_valid;
    check("clr_busy16_a", 32'(a_busy), 32'd0);
    check("clr_busy16_b", 32'(b_busy), 32'd0);
    tick();
    seen_valid = seen_valid | a_rd_valid | b_rd_valid;
    check("clr_no_valid", 32'(seen_valid), 32'd0);

    // Sweep all addresses back to back: everything zero, no bubbles
    for (int i = 0; i < 18; i++) begin
      rd_en = (i < 16); rd_addr = 4'(i);
      tick();
      if (i < 16) begin
        check($sformatf("sweep_valid_a%0d", i), 32'(a_rd_valid), 32'd1);
        check($sformatf("sweep_data_a%0d", i), 32'(a_rd_data), 32'd0);
      end else begin
        check($sformatf("sweep_idle_a%0d", i), 32'(a_rd_valid), 32'd0);
      end
      if (i >= 1 && i <= 16) begin
        check($sformatf("sweep_valid_b%0d", i), 32'(b_rd_valid), 32'd1);
        check($sformatf("sweep_data_b%0d", i), b_rd_data, 32'd0);
      end else begin
        check($sformatf("sweep_idle_b%0d", i), 32'(b_rd_valid), 32'd0);
      end
    end
    rd_en = 1'b0;

    // Write then read: latency 1 vs 2, data holds between reads
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h0000_00A5; wr_be = 4'hF;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    rd_en = 1'b0;
    check("lat_valid_a",  32'(a_rd_valid), 32'd1);
    check("lat_data_a",   32'(a_rd_data), 32'h0000_00A5);
    check("lat_early_b",  32'(b_rd_valid), 32'd0);
    tick();
    check("lat_pulse_a",  32'(a_rd_valid), 32'd0);
    check("lat_hold_a",   32'(a_rd_data), 32'h0000_00A5);
    check("lat_valid_b",  32'(b_rd_valid), 32'd1);
    check("lat_data_b",   b_rd_data, 32'h0000_00A5);
    tick();
    check("lat_pulse_b",  32'(b_rd_valid), 32'd0);

    // Byte enables
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h1122_3344; wr_be = 4'hF;
    tick();
    wr_data = 32'hAABB_CCDD; wr_be = 4'b0101;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    rd_en = 1'b0;
    check("be_data_a", 32'(a_rd_data), 32'h0000_00DD);
    tick();
    check("be_data_b", b_rd_data, 32'h11BB_33DD);

    // Same-address collision: A is read-first, B is write-first with merge
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h0000_0010; wr_be = 4'hF;
    tick();
    wr_data = 32'hEEEE_EE77; wr_be = 4'b0001; rd_en = 1'b1; rd_addr = 4'd9;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("rdw_old_a", 32'(a_rd_data), 32'h0000_0010);
    tick();
    check("rdw_new_b", b_rd_data, 32'h0000_0077);
    rd_en = 1'b1; rd_addr = 4'd9;
    tick();
    rd_en = 1'b0;
    check("rdw_after_a", 32'(a_rd_data), 32'h0000_0077);
    tick();
    check("rdw_after_b", b_rd_data, 32'h0000_0077);

    // wr_be = 0 leaves memory alone; different addresses never interact
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h5555_5555; wr_be = 4'h0;
    tick();
    wr_addr = 4'd2; wr_data = 32'h3333_3333; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd9;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("be0_diff_a", 32'(a_rd_data), 32'h0000_0077);
    tick();
    check("be0_diff_b", b_rd_data, 32'h0000_0077);

    // Reset mid-clear
    rst_n = 1'b0;
    #1;
    check("rst2_data_a",  32'(a_rd_data), 32'd0);
    check("rst2_data_b",  b_rd_data, 32'd0);
    check("rst2_busy_b",  32'(b_busy), 32'd1);
    check("rst2_busy_c",  32'(c_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (7) tick();
    check("mid_busy7_a", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    seen_valid = 1'b0; seen_data = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen_valid = seen_valid | a_rd_valid | b_rd_valid;
      seen_data  = seen_data | 32'(a_rd_data) | b_rd_data;
    end
    check("mid_busy15_a", 32'(a_busy), 32'd1);
    check("mid_busy15_b", 32'(b_busy), 32'd1);
    tick();
    seen_valid = seen_valid | a_rd_valid | b_rd_valid;
    seen_data  = seen_data | 32'(a_rd_data) | b_rd_data;
    check("mid_busy16_a", 32'(a_busy), 32'd0);
    check("mid_busy16_b", 32'(b_busy), 32'd0);
    check("mid_no_valid", 32'(seen_valid), 32'd0);
    check("mid_no_data",  seen_data, 32'd0);

    // Array was re-cleared
    rd_en = 1'b1; rd_addr = 4'd9;
    tick();
    rd_en = 1'b0;
    check("reclr_valid_a", 32'(a_rd_valid), 32'd1);
    check("reclr_data_a",  32'(a_rd_data), 32'd0);
    tick();
    check("reclr_valid_b", 32'(b_rd_valid), 32'd1);
    check("reclr_data_b",  b_rd_data, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
